// File: rtl/silu_pkg.sv
// Shared fixed-point format and constants for the SiLU backward pass.
package silu_pkg;

  localparam int IL = 4;
  localparam int FL = 16;
  localparam int W  = IL + FL;

  typedef logic signed [W-1:0] fxp_t;

  localparam fxp_t ONE  = fxp_t'(1) << FL;
  localparam fxp_t HALF = fxp_t'(1) << (FL - 1);
  localparam fxp_t FOUR = fxp_t'(4) << FL;
  localparam fxp_t MAXV = {1'b0, {(W-1){1'b1}}};
  localparam fxp_t MINV = {1'b1, {(W-1){1'b0}}};

endpackage

// File: rtl/fxp_mul_sat.sv
// Signed W x W fixed-point multiply, arithmetic >>> FL, clamp to W bits.
module fxp_mul_sat #(
  parameter int W  = 20,
  parameter int FL = 16
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y
);

  localparam logic signed [2*W-1:0] HI =
    {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] LO =
    {{(W+1){1'b1}}, {(W-1){1'b0}}};

  logic signed [2*W-1:0] p;
  logic signed [2*W-1:0] s;

  always_comb begin
    p = a * b;
    s = p >>> FL;
    if (s > HI)
      y = {1'b0, {(W-1){1'b1}}};
    else if (s < LO)
      y = {1'b1, {(W-1){1'b0}}};
    else
      y = s[W-1:0];
  end

endmodule

// File: rtl/silu_backward.sv
// dx = g * silu'(x) with a piecewise-quadratic sigmoid, 3-stage
// valid/ready pipeline with a single global advance.
module silu_backward
  import silu_pkg::*;
#(
  parameter int IL = silu_pkg::IL,
  parameter int FL = silu_pkg::FL
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IL+FL-1:0] x,
  input  logic signed [IL+FL-1:0] g,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [IL+FL-1:0] dx
);

  localparam int WD = IL + FL;
  localparam logic signed [WD-1:0] K_ONE  = WD'(1) << FL;
  localparam logic signed [WD-1:0] K_FOUR = WD'(4) << FL;
  localparam logic signed [WD-1:0] K_MAX  = {1'b0, {(WD-1){1'b1}}};
  localparam logic signed [WD-1:0] K_MIN  = {1'b1, {(WD-1){1'b0}}};

  logic adv;

  logic                  s1_v, s1_neg;
  logic signed [WD-1:0]  s1_x, s1_g, s1_t;
  logic                  s2_v;
  logic signed [WD-1:0]  s2_x, s2_g, s2_sig, s2_sigp;

  logic signed [WD-1:0]   a, t_n, h, sig_n, sigp_n, deriv, prod;
  logic signed [2*WD-1:0] tt, xs;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv || reset;

  always_comb begin
    // |x| with the most-negative code folded onto +MAX
    if (x == K_MIN)
      a = K_MAX;
    else if (x[WD-1])
      a = -x;
    else
      a = x;
    t_n = (a < K_FOUR) ? K_ONE - (a >>> 2) : '0;
  end

  always_comb begin
    tt     = s1_t * s1_t;
    h      = WD'(tt >>> (FL + 1));
    sig_n  = s1_neg ? h : K_ONE - h;
    sigp_n = s1_t >>> 2;
  end

  always_comb begin
    xs    = s2_x * s2_sigp;
    deriv = s2_sig + WD'(xs >>> FL);
  end

  fxp_mul_sat #(.W(WD), .FL(FL)) u_mul (
    .a (s2_g),
    .b (deriv),
    .y (prod)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      out_valid <= 1'b0;
      dx        <= '0;
      s1_neg    <= 1'b0;
      s1_x      <= '0;
      s1_g      <= '0;
      s1_t      <= '0;
      s2_x      <= '0;
      s2_g      <= '0;
      s2_sig    <= '0;
      s2_sigp   <= '0;
    end else if (adv) begin
      s1_v      <= in_valid;
      s1_neg    <= x[WD-1];
      s1_x      <= x;
      s1_g      <= g;
      s1_t      <= t_n;
      s2_v      <= s1_v;
      s2_x      <= s1_x;
      s2_g      <= s1_g;
      s2_sig    <= sig_n;
      s2_sigp   <= sigp_n;
      out_valid <= s2_v;
      dx        <= prod;
    end
  end

endmodule

// File: tb/tb_silu_backward.sv
// Directed vectors, stall stream and mid-flight reset for silu_backward.
module tb_silu_backward;

  localparam int W = 20;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready;
  logic signed [W-1:0] x, g, dx;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  silu_backward dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .g         (g),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dx        (dx)
  );

  typedef struct {
    string          name;
    logic [W-1:0]   x;
    logic [W-1:0]   g;
    logic [W-1:0]   dx;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    @(negedge clk);
    in_valid  = 1'b1;
    x         = v.x;
    g         = v.g;
    out_ready = 1'b1;
    #1 chk({v.name, "/rdy"}, W'(in_ready), W'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({v.name, "/lat"}, W'(lat), W'(3));
    chk(v.name, dx, v.dx);
  endtask

  initial begin
    int acc, got, nout;
    logic [W-1:0] held;
    logic exp_rdy;

    tbl[0]  = '{"zero",    20'h00000, 20'h10000, 20'h08000};
    tbl[1]  = '{"pos2",    20'h20000, 20'h10000, 20'h12000};
    tbl[2]  = '{"neg2",    20'hE0000, 20'h10000, 20'hFE000};
    tbl[3]  = '{"pos5",    20'h50000, 20'hD0000, 20'hD0000};
    tbl[4]  = '{"neg5",    20'hB0000, 20'h12345, 20'h00000};
    tbl[5]  = '{"satpos",  20'h20000, 20'h78000, 20'h7FFFF};
    tbl[6]  = '{"satneg",  20'h20000, 20'h88000, 20'h80000};
    tbl[7]  = '{"mostneg", 20'h80000, 20'h10000, 20'h00000};
    tbl[8]  = '{"pos4",    20'h40000, 20'h10000, 20'h10000};
    tbl[9]  = '{"neg4",    20'hC0000, 20'h10000, 20'h00000};
    tbl[10] = '{"pos1",    20'h10000, 20'h10000, 20'h0E800};
    tbl[11] = '{"floor",   20'h00001, 20'hFFFFF, 20'hFFFFF};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x         = '0;
    g         = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ov",  W'(out_valid), W'(0));
    chk("rst_dx",  dx, W'(0));
    chk("rst_rdy", W'(in_ready), W'(1));
    reset = 1'b0;

    for (int i = 0; i < 12; i++)
      run_vec(tbl[i]);

    // 8-deep stream, downstream stalled on cycles 4..6
    acc = 0;
    got = 0;
    held = '0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      exp_rdy   = !(c >= 4 && c <= 6);
      out_ready = exp_rdy;
      in_valid  = (acc < 8);
      x         = '0;
      g         = W'((acc + 1) * 'h1000);
      #1;
      chk($sformatf("stream_rdy%0d", c), W'(in_ready), W'(exp_rdy));
      if (c == 4) held = dx;
      if (c == 5 || c == 6) begin
        chk($sformatf("stream_hold%0d", c), dx, held);
        chk($sformatf("stream_ovh%0d", c), W'(out_valid), W'(1));
      end
      if (in_valid && in_ready) acc++;
      if (out_valid && out_ready) begin
        chk($sformatf("stream_dx%0d", got), dx, W'((got + 1) * 'h800));
        got++;
      end
    end
    chk("stream_cnt", W'(got), W'(8));
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("stream_nodup", W'(out_valid), W'(0));

    // reset with three results in flight
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      x        = '0;
      g        = 20'h07000;
    end
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    #1 chk("midrst_rdy", W'(in_ready), W'(1));
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("midrst_ov", W'(out_valid), W'(0));
    chk("midrst_dx", dx, W'(0));
    @(negedge clk);
    in_valid = 1'b1;
    g        = 20'h02000;
    @(negedge clk);
    in_valid = 1'b0;
    nout = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) begin
        chk("post_dx", dx, 20'h01000);
        nout++;
      end
      @(negedge clk);
    end
    chk("post_cnt", W'(nout), W'(1));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/silu_backward.md
SILU_BACKWARD -- requirements
Module: silu_backward

Interface
REQ-001 Parameter IL, default 4, integer bits of the signed fixed-point format, sign included.
REQ-002 Parameter FL, default 16, fractional bits; W = IL+FL (20 by default).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  x/g pair offered this cycle.
REQ-006 in_ready  output  1  block accepts the pair this cycle.
REQ-007 x  input  W signed  forward-pass activation input, QIL.FL.
REQ-008 g  input  W signed  upstream gradient dL/dy, QIL.FL.
REQ-009 out_valid  output  1  dx holds a valid result.
REQ-010 out_ready  input  1  downstream accepts dx this cycle.
REQ-011 dx  output  W signed  gradient dL/dx = g * silu'(x), QIL.FL.

Function
REQ-012 Transfers SHALL occur only on in_valid&&in_ready (input) and out_valid&&out_ready (output).
REQ-013 The datapath SHALL be a 3-stage pipeline (S1, S2, S3), each stage with its own valid bit; dx/out_valid are S3 registers.
REQ-014 Pipeline advance SHALL be adv = !out_valid || out_ready; all stages load only when adv=1.
REQ-015 in_ready SHALL equal adv (combinational, no dependency on in_valid).
REQ-016 Latency SHALL be exactly 3 clk edges from an accepted input to out_valid, with no stall.
REQ-017 Throughput SHALL be one result per cycle while out_ready stays high.
REQ-018 While out_valid && !out_ready, dx, out_valid and every stage register SHALL hold unchanged.
REQ-019 Bubbles (adv=1, in_valid=0) SHALL propagate as valid=0; results SHALL leave in acceptance order.
REQ-020 S1 arithmetic: a = |x|, with x = most-negative saturating to the maximum positive value.
REQ-021 S1 arithmetic: t = ONE - (a>>>2) if a < FOUR, else t = 0; sign of x, x and g carried forward.
REQ-022 S2 arithmetic: h = (t*t)>>>(FL+1), i.e. 0.5*t^2.
REQ-023 S2 arithmetic: sig = h when x<0, otherwise ONE - h; sigp = t>>>2.
REQ-024 S3 arithmetic: deriv = sig + ((x*sigp)>>>FL).
REQ-025 S3 arithmetic: dx = sat_W((g*deriv)>>>FL).
REQ-026 Every multiply SHALL be full 2W-bit signed; all shifts arithmetic (truncate toward -inf), no rounding.
REQ-027 sat_W SHALL clamp to [MINV, MAXV] = [-2^(W-1), 2^(W-1)-1] LSBs.
REQ-028 For |x| >= 4.0, deriv SHALL be exactly ONE (x>=0) or 0 (x<0).
REQ-029 Simultaneous output accept and input accept in one cycle SHALL both take effect (full-rate flow).

Reset
REQ-030 While reset=1, all stage valid bits and out_valid SHALL be 0 and dx SHALL be 0 at the next edge.
REQ-031 While reset=1, in_ready SHALL be 1.
REQ-032 Reset mid-operation SHALL discard all in-flight data; no result of a pre-reset input SHALL ever appear.
REQ-033 Reset SHALL take priority over any simultaneous handshake.

Structure
REQ-034 Package silu_pkg SHALL hold IL, FL, W and the constants ONE, HALF, FOUR, MAXV, MINV, plus the fixed-point type typedef.
REQ-035 Sub-module fxp_mul_sat (signed W x W multiply, >>>FL, saturate to W) SHALL be instantiated for the S3 g*deriv product.

Verification
REQ-036 x=0x00000, g=0x10000 -> dx=0x08000 (0.5) exactly 3 cycles after acceptance.
REQ-037 x=0x20000 (2.0), g=0x10000 -> dx=0x12000 (1.125); x=0xE0000 (-2.0), same g -> dx=0xFE000 (-0.125).
REQ-038 x=0x50000 (5.0), g=0xD0000 (-3.0) -> dx=0xD0000; x=0xB0000 (-5.0), any g -> dx=0x00000.
REQ-039 x=0x20000, g=0x78000 (7.5) -> dx saturates to 0x7FFFF; x=0x80000 (most negative) -> no overflow, deriv=0.
REQ-040 Back-to-back stream of 8 inputs, with out_ready low for cycles 4-6 -> in_ready low exactly those cycles, dx held, all 8 results in order, none lost or duplicated.
REQ-041 Reset asserted with 3 results in flight -> out_valid=0 the next cycle, in_ready=1, and only post-reset inputs ever emerge.
